aes_entropy_responder: RTL

//  Responder end of the cipher core's entropy endpoint. It answers the core's entropy
//  req/ack handshake with fresh pseudo-random words from a bank of 32-bit Galois LFSR lanes.
//  It sits beside aes_cipher_core_wrapper and connects to its _entr_ep_req_* / _entr_ep_res_0

---
 rtl/aes_entropy_responder.sv | 126 ++++++++++++
 1 files changed

// File: rtl/aes_entropy_responder.sv
// Entropy responder for the cipher core: answers req/ack with words from a bank of
// 32-bit Galois LFSR lanes, with a seed endpoint that can reload them.
module aes_entropy_responder #(
  parameter int unsigned Width       = 128,
  parameter int unsigned Latency     = 2,
  parameter logic [31:0] Poly        = 32'h8020_0003,
  parameter logic [31:0] DefaultSeed = 32'hC0FF_EE01
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             _ep_req_valid,
  input  logic             _ep_req_0,
  output logic             _ep_req_ack,
  output logic [Width-1:0] _ep_res_0,
  input  logic             _ep_seed_valid,
  input  logic [Width-1:0] _ep_seed_0,
  output logic             _ep_seed_ack
);

  localparam int unsigned NumLanes = Width / 32;
  localparam int unsigned CntW     = $clog2(16);
  localparam logic [CntW-1:0] LatCnt = CntW'(Latency);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GEN  = 2'd1,
    ACK  = 2'd2
  } state_e;

  state_e                     state_q, state_d;
  logic [CntW-1:0]            cnt_q, cnt_d;
  logic [NumLanes-1:0][31:0]  lanes_q, lanes_d;
  logic                       ack_q;
  logic [Width-1:0]           res_q;
  logic                       unused_req_payload;

  assign unused_req_payload = _ep_req_0;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ Poly) : (s >> 1);
  endfunction

  function automatic logic [31:0] lane_default(input int unsigned idx);
    return DefaultSeed + 32'(idx);
  endfunction

  // Next-state, counter and lane update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lanes_d = lanes_q;
    case (state_q)
      IDLE: begin
        if (_ep_seed_valid) begin
          // A zero lane would lock the LFSR, so it takes the default seed instead.
          for (int i = 0; i < NumLanes; i++) begin
            if (_ep_seed_0[32*i +: 32] == 32'h0) begin
              lanes_d[i] = lane_default(i);
            end else begin
              lanes_d[i] = _ep_seed_0[32*i +: 32];
            end
          end
        end else if (_ep_req_valid) begin
          cnt_d   = LatCnt;
          state_d = (LatCnt != {CntW{1'b0}}) ? GEN : ACK;
        end else begin
          state_d = IDLE;
        end
      end
      GEN: begin
        if (!_ep_req_valid) begin
          state_d = IDLE;
        end else begin
          for (int i = 0; i < NumLanes; i++) begin
            lanes_d[i] = lfsr_step(lanes_q[i]);
          end
          cnt_d   = cnt_q - {{(CntW-1){1'b0}}, 1'b1};
          state_d = (cnt_q == {{(CntW-1){1'b0}}, 1'b1}) ? ACK : GEN;
        end
      end
      ACK: begin
        for (int i = 0; i < NumLanes; i++) begin
          lanes_d[i] = lfsr_step(lanes_q[i]);
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counter and lane registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= {CntW{1'b0}};
      for (int i = 0; i < NumLanes; i++) begin
        lanes_q[i] <= lane_default(i);
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lanes_q <= lanes_d;
    end
  end

  // Response registers: ack and data are live only for the ACK cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack_q <= 1'b0;
      res_q <= {Width{1'b0}};
    end else if (state_d == ACK) begin
      ack_q <= 1'b1;
      res_q <= lanes_d;
    end else begin
      ack_q <= 1'b0;
      res_q <= {Width{1'b0}};
    end
  end

  assign _ep_req_ack  = ack_q;
  assign _ep_res_0    = res_q;
  assign _ep_seed_ack = _ep_seed_valid & (state_q == IDLE) & rst_ni;

endmodule
